// File: rtl/aes_mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine: one 32-bit column per clock over a 128-bit state,
// with valid/ready handshakes on both the input and the output side.
module aes_mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e       fsm_q;
    logic [1:0]   col_q;
    logic [127:0] src_q;
    logic [127:0] out_q;
    logic [127:0] out_d;
    logic         inv_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [7:0]   a  [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   fwd_b [4];
    logic [7:0]   inv_b [4];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    always_comb begin
        col_in = src_q[127:96];
        case (col_q)
            2'd0: col_in = src_q[127:96];
            2'd1: col_in = src_q[95:64];
            2'd2: col_in = src_q[63:32];
            2'd3: col_in = src_q[31:0];
            default: col_in = src_q[127:96];
        endcase
    end

    // One multiply path per row; every constant is an XOR of the x, 2x, 4x, 8x chain.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            localparam int R1 = (gi + 1) % 4;
            localparam int R2 = (gi + 2) % 4;
            localparam int R3 = (gi + 3) % 4;

            assign a[gi]  = col_in[31 - 8*gi -: 8];
            assign x2[gi] = xtime(a[gi]);
            assign x4[gi] = xtime(x2[gi]);
            assign x8[gi] = xtime(x4[gi]);

            assign fwd_b[gi] = x2[gi] ^ (x2[R1] ^ a[R1]) ^ a[R2] ^ a[R3];
            assign inv_b[gi] = (x8[gi] ^ x4[gi] ^ x2[gi])
                             ^ (x8[R1] ^ x2[R1] ^ a[R1])
                             ^ (x8[R2] ^ x4[R2] ^ a[R2])
                             ^ (x8[R3] ^ a[R3]);

            assign col_out[31 - 8*gi -: 8] = inv_q ? inv_b[gi] : fwd_b[gi];
        end
    endgenerate

    always_comb begin
        out_d = out_q;
        case (col_q)
            2'd0: out_d[127:96] = col_out;
            2'd1: out_d[95:64]  = col_out;
            2'd2: out_d[63:32]  = col_out;
            2'd3: out_d[31:0]   = col_out;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            col_q       <= 2'd0;
            src_q       <= '0;
            out_q       <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        src_q      <= state_in;
                        inv_q      <= inverse;
                        col_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        fsm_q      <= CALC;
                    end
                end
                CALC: begin
                    out_q <= out_d;
                    col_q <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end
                end
                DONE: begin
                    // No re-accept here: a waiting input is taken in the following IDLE cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = out_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: GF(2^8) matrix model, per-cycle protocol compare,
// directed FIPS-197 vectors, back-pressure, mid-operation reset and random round trips.
`timescale 1ns/1ps
module tb_aes_mix_columns_seq;
    localparam logic [127:0] F_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] F_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         inverse = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] state_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] state_out;

    int n_checks = 0;
    int n_fail = 0;
    int rdy_mode = 0;
    logic [127:0] got_q[$];

    aes_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .inverse   (inverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] p = 8'h00;
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Circulant coefficient matrix applied to each column.
    function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
        logic [7:0]   base [4];
        logic [127:0] res = '0;
        logic [7:0]   acc;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - r + 4) % 4], st[127 - 8*(4*c + j) -: 8]);
                res[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Consumer side.
    initial begin : consumer
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else                    out_ready = 1'b0;
        end
    end

    // Per-cycle compare against the protocol/arithmetic model.
    initial begin : cmp
        bit           armed = 0;
        bit           m_busy = 0;
        bit           m_done = 0;
        bit           m_zero = 0;
        int           m_cnt = 0;
        logic [127:0] m_exp = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                check("in_ready", 128'(in_ready), 128'(!m_busy));
                check("busy", 128'(busy), 128'(m_busy));
                check("out_valid", 128'(out_valid), 128'(m_done));
                if (m_done)      check("state_out", state_out, m_exp);
                else if (m_zero) check("state_out_reset", state_out, 128'h0);
            end
            if (!rst_n) begin
                armed  = 1;
                m_busy = 0;
                m_done = 0;
                m_zero = 1;
            end else if (armed) begin
                if (!m_busy) begin
                    if (in_valid) begin
                        m_busy = 1;
                        m_cnt  = 0;
                        m_exp  = model(state_in, inverse);
                        m_zero = 0;
                    end
                end else if (!m_done) begin
                    m_cnt++;
                    if (m_cnt == 4) m_done = 1;
                end else if (out_ready) begin
                    got_q.push_back(state_out);
                    m_busy = 0;
                    m_done = 0;
                end
            end
        end
    end

    task automatic present(input logic [127:0] st, input logic inv);
        @(posedge clk);
        #1;
        state_in = st;
        inverse  = inv;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                state_in = {$urandom, $urandom, $urandom, $urandom};
                inverse  = ~inverse;
                return;
            end
        end
        in_valid = 1'b0;
        timeout_fail("accept");
    endtask

    task automatic get_result(output logic [127:0] r);
        r = '0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (got_q.size() > 0) begin
                r = got_q.pop_front();
                return;
            end
        end
        timeout_fail("result");
    endtask

    task automatic xact(input logic [127:0] st, input logic inv, output logic [127:0] r);
        present(st, inv);
        wait_accept();
        get_result(r);
    endtask

    logic [127:0] r0, r1, x, y, z;
    logic         m;
    int           sz;

    initial begin : main
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("model_fwd_fips", model(F_IN, 1'b0), F_OUT);
        check("model_inv_fips", model(F_OUT, 1'b1), F_IN);
        check("model_fwd_v2", model(V2_IN, 1'b0), V2_OUT);

        xact(F_IN, 1'b0, r0);
        $display("xact fwd  in=%h out=%h", F_IN, r0);
        check("dut_fwd_fips", r0, F_OUT);
        xact(F_OUT, 1'b1, r0);
        $display("xact inv  in=%h out=%h", F_OUT, r0);
        check("dut_inv_fips", r0, F_IN);
        xact(V2_IN, 1'b0, r0);
        $display("xact fwd  in=%h out=%h", V2_IN, r0);
        check("dut_fwd_v2", r0, V2_OUT);

        // Back-pressure with a second state waiting at the input.
        rdy_mode = 2;
        present(F_IN, 1'b0);
        wait_accept();
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        present(V2_OUT, 1'b1);
        repeat (10) @(negedge clk);
        check("bp_in_ready", 128'(in_ready), 128'h0);
        check("bp_out_valid", 128'(out_valid), 128'h1);
        check("bp_state_out", state_out, F_OUT);
        rdy_mode = 0;
        wait_accept();
        get_result(r0);
        get_result(r1);
        $display("xact bp   out0=%h out1=%h", r0, r1);
        check("bp_first", r0, F_OUT);
        check("bp_second", r1, V2_IN);

        // Reset while column 2 is being computed.
        present(V2_IN, 1'b0);
        wait_accept();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sz = got_q.size();
        repeat (20) @(negedge clk);
        $display("xact rst  dropped in=%h", V2_IN);
        check("no_result_after_reset", 128'(got_q.size()), 128'(sz));

        // Random round trips with random stalls on both sides.
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            xact(x, m, y);
            xact(y, !m, z);
            $display("xact rt   in=%h mode=%0d mid=%h back=%h", x, m, y, z);
            check("roundtrip", z, x);
        end
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
